// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: two requester FIFOs drained round-robin onto a
// registered write bus, with read-after-write hazard flags for both read ports.
module rf_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              rg_wrt_en,
    output logic [ADDR_W-1:0] rg_wrt_addr,
    output logic [DATA_W-1:0] rg_wrt_data,
    input  logic [ADDR_W-1:0] rg_rd_addr1,
    input  logic [ADDR_W-1:0] rg_rd_addr2,
    output logic              hz1,
    output logic              hz2
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] ent_addr_q [2][DEPTH];
    logic [DATA_W-1:0] ent_data_q [2][DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q [2];
    logic [PTR_W-1:0]  rd_ptr_d [2];
    logic [PTR_W-1:0]  wr_ptr_q [2];
    logic [PTR_W-1:0]  wr_ptr_d [2];
    logic [CNT_W-1:0]  cnt_q [2];
    logic [CNT_W-1:0]  cnt_d [2];
    logic              last_q;
    logic              wrt_en_q;
    logic [ADDR_W-1:0] wrt_addr_q;
    logic [DATA_W-1:0] wrt_data_q;

    logic [1:0]        in_valid;
    logic [ADDR_W-1:0] in_addr [2];
    logic [DATA_W-1:0] in_data [2];
    logic [1:0]        ready;
    logic [1:0]        push;
    logic [1:0]        cand;
    logic [1:0]        pop;
    logic              gnt_any;
    logic              gnt_idx;
    logic              hit1;
    logic              hit2;
    logic [PTR_W-1:0]  off;

    assign in_valid   = {req1_valid, req0_valid};
    assign in_addr[0] = req0_addr;
    assign in_addr[1] = req1_addr;
    assign in_data[0] = req0_data;
    assign in_data[1] = req1_data;

    // Ready looks only at occupancy: a full FIFO refuses even while it pops.
    always_comb begin
        ready   = '0;
        push    = '0;
        cand    = '0;
        pop     = '0;
        gnt_any = 1'b0;
        gnt_idx = 1'b0;
        for (int n = 0; n < 2; n++) begin
            ready[n] = reset && (cnt_q[n] != FULL);
            push[n]  = in_valid[n] && ready[n] && (in_addr[n] != '0);
            cand[n]  = (cnt_q[n] != '0);
        end
        gnt_any = |cand;
        gnt_idx = (cand[0] && cand[1]) ? ~last_q : cand[1];
        for (int n = 0; n < 2; n++) begin
            pop[n]      = gnt_any && (int'(gnt_idx) == n);
            rd_ptr_d[n] = rd_ptr_q[n] + PTR_W'(pop[n]);
            wr_ptr_d[n] = wr_ptr_q[n] + PTR_W'(push[n]);
            cnt_d[n]    = cnt_q[n] + CNT_W'(push[n]) - CNT_W'(pop[n]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int n = 0; n < 2; n++) begin
                rd_ptr_q[n] <= '0;
                wr_ptr_q[n] <= '0;
                cnt_q[n]    <= '0;
            end
            last_q     <= 1'b1;
            wrt_en_q   <= 1'b0;
            wrt_addr_q <= '0;
            wrt_data_q <= '0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                rd_ptr_q[n] <= rd_ptr_d[n];
                wr_ptr_q[n] <= wr_ptr_d[n];
                cnt_q[n]    <= cnt_d[n];
                if (push[n]) begin
                    ent_addr_q[n][wr_ptr_q[n]] <= in_addr[n];
                    ent_data_q[n][wr_ptr_q[n]] <= in_data[n];
                end
            end
            wrt_en_q <= gnt_any;
            if (gnt_any) begin
                wrt_addr_q <= ent_addr_q[gnt_idx][rd_ptr_q[gnt_idx]];
                wrt_data_q <= ent_data_q[gnt_idx][rd_ptr_q[gnt_idx]];
                last_q     <= gnt_idx;
            end
        end
    end

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        off  = '0;
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < DEPTH; i++) begin
                off = PTR_W'(i) - rd_ptr_q[n];
                if ({1'b0, off} < cnt_q[n]) begin
                    if (ent_addr_q[n][i] == rg_rd_addr1) hit1 = 1'b1;
                    if (ent_addr_q[n][i] == rg_rd_addr2) hit2 = 1'b1;
                end
            end
        end
        if (wrt_en_q && (wrt_addr_q == rg_rd_addr1)) hit1 = 1'b1;
        if (wrt_en_q && (wrt_addr_q == rg_rd_addr2)) hit2 = 1'b1;
    end

    assign hz1 = reset && (rg_rd_addr1 != '0) && hit1;
    assign hz2 = reset && (rg_rd_addr2 != '0) && hit2;

    assign req0_ready  = ready[0];
    assign req1_ready  = ready[1];
    assign rg_wrt_en   = wrt_en_q;
    assign rg_wrt_addr = wrt_addr_q;
    assign rg_wrt_data = wrt_data_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: single write, contention order, x0 discard,
// saturation with a per-requester scoreboard, and reset mid-operation.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req1_valid, req1_ready;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        rg_wrt_en;
    logic [4:0]  rg_wrt_addr;
    logic [31:0] rg_wrt_data;
    logic [4:0]  rg_rd_addr1, rg_rd_addr2;
    logic        hz1, hz2;

    int tests = 0;
    int fails = 0;

    logic [36:0] q0[$];
    logic [36:0] q1[$];
    int acc0 = 0, acc1 = 0, wr0 = 0, wr1 = 0, k0 = 0, k1 = 0;
    logic r0, r1;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .rg_wrt_en  (rg_wrt_en),
        .rg_wrt_addr(rg_wrt_addr),
        .rg_wrt_data(rg_wrt_data),
        .rg_rd_addr1(rg_rd_addr1),
        .rg_rd_addr2(rg_rd_addr2),
        .hz1        (hz1),
        .hz2        (hz2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Retire an observed write against the scoreboard of the requester owning its address range.
    task automatic retire();
        logic [36:0] exp;
        if (rg_wrt_en) begin
            if (rg_wrt_addr >= 5'd16) begin
                exp = (q1.size() > 0) ? q1.pop_front() : 37'h1F_FFFF_FFFF;
                chk("sat_wr1", 64'({rg_wrt_addr, rg_wrt_data}), 64'(exp));
                wr1++;
            end else begin
                exp = (q0.size() > 0) ? q0.pop_front() : 37'h1F_FFFF_FFFF;
                chk("sat_wr0", 64'({rg_wrt_addr, rg_wrt_data}), 64'(exp));
                wr0++;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        rg_rd_addr1 = '0; rg_rd_addr2 = '0;
        tick(); tick();
        rg_rd_addr1 = 5'd5;
        settle();
        chk("rst_en",   64'(rg_wrt_en),   64'(0));
        chk("rst_addr", 64'(rg_wrt_addr), 64'(0));
        chk("rst_data", 64'(rg_wrt_data), 64'(0));
        chk("rst_rdy0", 64'(req0_ready),  64'(0));
        chk("rst_rdy1", 64'(req1_ready),  64'(0));
        chk("rst_hz1",  64'(hz1),         64'(0));

        // single write, accepted at edge 1
        reset = 1'b1;
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
        rg_rd_addr2 = 5'd7;
        settle();
        chk("t1_rdy0",   64'(req0_ready), 64'(1));
        chk("t1_hz1pre", 64'(hz1),        64'(0));
        tick();
        req0_valid = 1'b0;
        settle();
        chk("t1_e1_en",  64'(rg_wrt_en), 64'(0));
        chk("t1_e1_hz1", 64'(hz1),       64'(1));
        chk("t1_e1_hz2", 64'(hz2),       64'(0));
        tick();
        chk("t1_e2_en",   64'(rg_wrt_en),   64'(1));
        chk("t1_e2_addr", 64'(rg_wrt_addr), 64'(5));
        chk("t1_e2_data", 64'(rg_wrt_data), 64'(32'hDEADBEEF));
        chk("t1_e2_hz1",  64'(hz1),         64'(1));
        tick();
        chk("t1_e3_en",   64'(rg_wrt_en),   64'(0));
        chk("t1_e3_hold", 64'(rg_wrt_addr), 64'(5));
        chk("t1_e3_hz1",  64'(hz1),         64'(0));

        // contention after a reset pulse so requester 0 wins the first tie
        reset = 1'b0;
        tick();
        reset = 1'b1;
        req0_valid = 1'b1; req0_addr = 5'd1;  req0_data = 32'h100;
        req1_valid = 1'b1; req1_addr = 5'd11; req1_data = 32'h1100;
        rg_rd_addr2 = 5'd11;
        settle();
        chk("c_rdy0_a", 64'(req0_ready), 64'(1));
        chk("c_rdy1_a", 64'(req1_ready), 64'(1));
        tick();
        req0_addr = 5'd2;  req0_data = 32'h200;
        req1_addr = 5'd12; req1_data = 32'h1200;
        settle();
        chk("c_e1_en",   64'(rg_wrt_en),  64'(0));
        chk("c_e1_hz2",  64'(hz2),        64'(1));
        chk("c_e1_rdy0", 64'(req0_ready), 64'(1));
        chk("c_e1_rdy1", 64'(req1_ready), 64'(1));
        tick();
        req0_addr = 5'd3;  req0_data = 32'h300;
        req1_addr = 5'd13; req1_data = 32'h1300;
        settle();
        chk("c_e2_en",   64'(rg_wrt_en),   64'(1));
        chk("c_e2_addr", 64'(rg_wrt_addr), 64'(1));
        chk("c_e2_data", 64'(rg_wrt_data), 64'(32'h100));
        chk("c_e2_rdy0", 64'(req0_ready),  64'(1));
        chk("c_e2_rdy1", 64'(req1_ready),  64'(0));
        tick();
        req0_valid = 1'b0;
        settle();
        chk("c_e3_addr", 64'(rg_wrt_addr), 64'(11));
        chk("c_e3_data", 64'(rg_wrt_data), 64'(32'h1100));
        chk("c_e3_rdy0", 64'(req0_ready),  64'(0));
        chk("c_e3_rdy1", 64'(req1_ready),  64'(1));
        tick();
        req1_valid = 1'b0;
        settle();
        chk("c_e4_addr", 64'(rg_wrt_addr), 64'(2));
        chk("c_e4_rdy0", 64'(req0_ready),  64'(1));
        chk("c_e4_rdy1", 64'(req1_ready),  64'(0));
        tick();
        chk("c_e5_addr", 64'(rg_wrt_addr), 64'(12));
        chk("c_e5_data", 64'(rg_wrt_data), 64'(32'h1200));
        tick();
        chk("c_e6_addr", 64'(rg_wrt_addr), 64'(3));
        tick();
        chk("c_e7_addr", 64'(rg_wrt_addr), 64'(13));
        chk("c_e7_data", 64'(rg_wrt_data), 64'(32'h1300));
        tick();
        chk("c_e8_en",   64'(rg_wrt_en),   64'(0));

        // x0 writes complete but are dropped
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h1;
        rg_rd_addr1 = '0; rg_rd_addr2 = '0;
        settle();
        chk("x0_rdy1", 64'(req1_ready), 64'(1));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("x0_en",   64'(rg_wrt_en),  64'(0));
            chk("x0_rdy1", 64'(req1_ready), 64'(1));
            chk("x0_hz1",  64'(hz1),        64'(0));
            chk("x0_hz2",  64'(hz2),        64'(0));
        end
        req1_valid = 1'b0;
        tick();
        chk("x0_en_end", 64'(rg_wrt_en), 64'(0));

        // both requesters saturating, scoreboard per requester
        for (int c = 0; c < 20; c++) begin
            req0_valid = 1'b1; req0_addr = 5'(1 + (k0 % 7));  req0_data = 32'hA000_0000 + 32'(k0);
            req1_valid = 1'b1; req1_addr = 5'(16 + (k1 % 15)); req1_data = 32'hB000_0000 + 32'(k1);
            settle();
            chk("sat_rdy0", 64'(req0_ready), 64'((acc0 - wr0) != 2));
            chk("sat_rdy1", 64'(req1_ready), 64'((acc1 - wr1) != 2));
            r0 = req0_ready;
            r1 = req1_ready;
            tick();
            if (r0) begin q0.push_back({req0_addr, req0_data}); acc0++; k0++; end
            if (r1) begin q1.push_back({req1_addr, req1_data}); acc1++; k1++; end
            retire();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            retire();
        end
        chk("sat_q0_left", 64'(q0.size()), 64'(0));
        chk("sat_q1_left", 64'(q1.size()), 64'(0));
        chk("sat_min0",    64'(acc0 >= 8), 64'(1));
        chk("sat_min1",    64'(acc1 >= 8), 64'(1));

        // reset while both FIFOs hold entries
        req0_valid = 1'b1; req0_addr = 5'd4;  req0_data = 32'h44;
        req1_valid = 1'b1; req1_addr = 5'd20; req1_data = 32'h2020;
        settle();
        tick();
        req0_addr = 5'd5;  req0_data = 32'h55;
        req1_addr = 5'd21; req1_data = 32'h2121;
        settle();
        tick();
        reset = 1'b0;
        req0_addr = 5'd6;  req0_data = 32'h66;
        req1_addr = 5'd22; req1_data = 32'h2222;
        rg_rd_addr1 = 5'd5; rg_rd_addr2 = 5'd21;
        settle();
        chk("mr_rdy0", 64'(req0_ready), 64'(0));
        chk("mr_rdy1", 64'(req1_ready), 64'(0));
        chk("mr_hz1",  64'(hz1),        64'(0));
        chk("mr_hz2",  64'(hz2),        64'(0));
        tick();
        chk("mr_en",   64'(rg_wrt_en),   64'(0));
        chk("mr_addr", 64'(rg_wrt_addr), 64'(0));
        chk("mr_data", 64'(rg_wrt_data), 64'(0));
        reset = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        settle();
        chk("mr_rel_rdy0", 64'(req0_ready), 64'(1));
        chk("mr_rel_rdy1", 64'(req1_ready), 64'(1));
        chk("mr_rel_hz1",  64'(hz1),        64'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mr_quiet_en", 64'(rg_wrt_en), 64'(0));
        end
        req0_valid = 1'b1; req0_addr = 5'd7;  req0_data = 32'h77;
        req1_valid = 1'b1; req1_addr = 5'd23; req1_data = 32'h2323;
        settle();
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        settle();
        tick();
        chk("tie_en1",   64'(rg_wrt_en),   64'(1));
        chk("tie_addr1", 64'(rg_wrt_addr), 64'(7));
        chk("tie_data1", 64'(rg_wrt_data), 64'(32'h77));
        tick();
        chk("tie_addr2", 64'(rg_wrt_addr), 64'(23));
        chk("tie_data2", 64'(rg_wrt_data), 64'(32'h2323));
        tick();
        chk("tie_en_end", 64'(rg_wrt_en), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Shares the register file's single write port between two writeback requesters: requester 0 is the pipeline writeback stage and requester 1 is the multi-cycle unit (load/mul). Each requester has a valid/ready handshake into a small FIFO. A round-robin arbiter drains the FIFO heads onto the registered `rg_wrt_*` bus, one write per cycle. The block also flags read-after-write hazards on both register-file read addresses so the datapath can stall.

## Interface
- `DATA_W`, 32, write data width
- `ADDR_W`, 5, register address width
- `DEPTH`, 2, entries per requester FIFO; power of two, ≥2

Ports:
- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-low; sampled only on rising `clk`
- `req0_valid`  in  1  requester 0 has a write
- `req0_ready`  out  1  requester 0 write accepted at this edge if valid
- `req0_addr`  in  ADDR_W  requester 0 destination register
- `req0_data`  in  DATA_W  requester 0 write data
- `req1_valid`, `req1_ready`, `req1_addr`, `req1_data`  same as requester 0, for requester 1
- `rg_wrt_en`  out  1  register file write enable, registered
- `rg_wrt_addr`  out  ADDR_W  register file write address, registered
- `rg_wrt_data`  out  DATA_W  register file write data, registered
- `rg_rd_addr1`  in  ADDR_W  read port 1 address, for hazard check
- `rg_rd_addr2`  in  ADDR_W  read port 2 address, for hazard check
- `hz1`  out  1  pending write to `rg_rd_addr1`
- `hz2`  out  1  pending write to `rg_rd_addr2`

## Operation
- Per requester: one FIFO of `DEPTH` entries {addr, data}, with a read pointer, a write pointer and an occupancy count (width clog2(DEPTH)+1). Pointers wrap modulo `DEPTH`.
- Handshake:
  - `reqN_ready = reset & (countN != DEPTH)`. It does not depend on `reqN_valid` or on a same-cycle pop.
  - A full FIFO deasserts ready even when it is popping in that cycle. There is no pass-through.
  - Transfer happens when valid and ready are both high at a rising edge. Valid may rise at any time; the requester holds addr/data until the transfer.
- x0 writes: a transfer with `reqN_addr == 0` completes normally (ready honoured) but is discarded, not enqueued. `rg_wrt_en` never asserts with address 0.
- Arbitration is evaluated every cycle on the FIFO heads (not-empty = candidate):
  - One candidate: grant it.
  - Two candidates: grant the index not equal to `last`.
  - None: no grant.
- On a grant:
  - Pop that head.
  - Load `rg_wrt_addr`/`rg_wrt_data` and set `rg_wrt_en=1`.
  - Set `last` = granted index.
- On no grant: `rg_wrt_en=0`; addr and data hold their previous values.
- Ordering: FIFO order is preserved within a requester. There is no ordering guarantee between requesters. The issuing logic must not have writes to the same register outstanding from both requesters.
- Push and pop on the same FIFO in the same cycle: count unchanged, both pointers advance.
- Hazard outputs (combinational):
  - `hzK = (rg_rd_addrK != 0)` AND the address matches any valid entry of either FIFO, or matches `rg_wrt_addr` while `rg_wrt_en=1`.
  - Entries being pushed in the current cycle are not included.
- Reset (`reset==0` at a rising edge):
  - Both FIFOs are emptied and pending entries discarded; no write is issued for them.
  - `last=1`, so requester 0 wins the first tie.
  - `rg_wrt_en=0`, `rg_wrt_addr=0`, `rg_wrt_data=0`.
  - While `reset==0`: `req0_ready=req1_ready=0`, and `hz1=hz2=0` because all entries are invalid.
  - Reset mid-operation has the same effect at that edge; in-flight handshakes at that edge are not accepted.

## Timing
- Edge k: request accepted into an empty FIFO, no contention.
- Cycle after edge k: the entry is the FIFO head and is granted.
- Edge k+1: output register loaded; `rg_wrt_en=1` during the cycle after edge k+1.
- Edge k+2: the register file captures the write.
- Minimum acceptance-to-write latency is 2 edges. Throughput is 1 write per cycle total.
- Both requesters streaming continuously: grants alternate 0,1,0,1. Each requester sees 1 pop per 2 cycles, so each FIFO fills and its ready toggles.
- `hzK` asserts in the cycle after the acceptance edge. It stays high until the cycle after the write edge (edge k+2) for that address.

## Test plan
- Reset then single write: release reset, `req0` {addr=5, data=0xDEADBEEF} accepted at edge 1 → `rg_wrt_en=1`, addr=5, data=0xDEADBEEF during cycle after edge 2 only. `hz1` high for `rg_rd_addr1=5` during cycles after edges 1 and 2.
- Contention: both valid every cycle, req0 addrs 1,2,3 and req1 addrs 11,12,13 → write sequence 1,11,2,12,3,13. `req0_ready` and `req1_ready` drop when count reaches 2.
- x0 discard: `req1` {addr=0, data=0x1} → `req1_ready=1`, transfer completes, `rg_wrt_en` stays 0, `hz1`/`hz2` stay 0 with read addresses 0.
- Full FIFO: hold `req0_valid` with a new address each cycle while `req1` is saturating → `req0_ready=0` whenever count=2, including cycles where a pop occurs. No entry is lost or duplicated; a scoreboard matches the write order per requester.
- Reset mid-operation: fill both FIFOs (4 entries), assert `reset=0` for 1 edge → no further `rg_wrt_en`, all readies 0 during reset. After release, readies are 1 and the first tie grants requester 0.
